// File: rtl/change_dispenser.sv
// Coin change dispenser: pays out owed change as dimes/nickels through a
// request/ack hopper handshake, with inventory tracking and jam timeout.
module change_dispenser #(
    parameter int unsigned NICKLE_INIT = 8,
    parameter int unsigned DIME_INIT   = 8,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_soda,
    input  logic [2:0]       i_change,
    input  logic             i_refill,
    input  logic             i_coin_ack,
    output logic             o_nickle_out,
    output logic             o_dime_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_short,
    output logic [2:0]       o_owed,
    output logic [CNT_W-1:0] o_nickle_cnt,
    output logic [CNT_W-1:0] o_dime_cnt
);

    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StWaitAck,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             dime_sel_q, dime_sel_d;
    logic [CNT_W-1:0] nickle_cnt_q, nickle_cnt_d;
    logic [CNT_W-1:0] dime_cnt_q, dime_cnt_d;

    logic             nickle_out_q, dime_out_q, busy_q, done_q, short_q;
    logic [2:0]       owed_q;
    logic             nickle_out_d, dime_out_d, busy_d, done_d, short_d;
    logic [2:0]       owed_d;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        timer_d      = timer_q;
        dime_sel_d   = dime_sel_q;
        nickle_cnt_d = nickle_cnt_q;
        dime_cnt_d   = dime_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (i_refill) begin
                    nickle_cnt_d = CNT_W'(NICKLE_INIT);
                    dime_cnt_d   = CNT_W'(DIME_INIT);
                end
                if (i_soda) begin
                    rem_d   = i_change;
                    // Invalid codes skip payout and report the whole code as owed.
                    state_d = (i_change <= 3'd4) ? StSelect : StFinish;
                end
            end
            StSelect: begin
                timer_d = '0;
                if (rem_q == 3'd0) begin
                    state_d = StFinish;
                end else if (rem_q >= 3'd2 && dime_cnt_q != '0) begin
                    dime_sel_d = 1'b1;
                    state_d    = StWaitAck;
                end else if (nickle_cnt_q != '0) begin
                    dime_sel_d = 1'b0;
                    state_d    = StWaitAck;
                end else begin
                    state_d = StFinish;
                end
            end
            StWaitAck: begin
                if (i_coin_ack) begin
                    if (dime_sel_q) begin
                        dime_cnt_d = dime_cnt_q - 1'b1;
                        rem_d      = rem_q - 3'd2;
                    end else begin
                        nickle_cnt_d = nickle_cnt_q - 1'b1;
                        rem_d        = rem_q - 3'd1;
                    end
                    timer_d = '0;
                    state_d = StSelect;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TMR_W'(ACK_TIMEOUT)) begin
                        // Jammed hopper: treat that coin type as exhausted.
                        if (dime_sel_q) dime_cnt_d = '0;
                        else            nickle_cnt_d = '0;
                        timer_d = '0;
                        state_d = StSelect;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Outputs are registered from next-state so they line up with the state.
        dime_out_d   = (state_d == StWaitAck) && dime_sel_d;
        nickle_out_d = (state_d == StWaitAck) && !dime_sel_d;
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StFinish);
        owed_d       = done_d ? rem_d : 3'd0;
        short_d      = done_d && (rem_d != 3'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            rem_q        <= 3'd0;
            timer_q      <= '0;
            dime_sel_q   <= 1'b0;
            nickle_cnt_q <= CNT_W'(NICKLE_INIT);
            dime_cnt_q   <= CNT_W'(DIME_INIT);
            nickle_out_q <= 1'b0;
            dime_out_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            owed_q       <= 3'd0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            timer_q      <= timer_d;
            dime_sel_q   <= dime_sel_d;
            nickle_cnt_q <= nickle_cnt_d;
            dime_cnt_q   <= dime_cnt_d;
            nickle_out_q <= nickle_out_d;
            dime_out_q   <= dime_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            short_q      <= short_d;
            owed_q       <= owed_d;
        end
    end

    assign o_nickle_out = nickle_out_q;
    assign o_dime_out   = dime_out_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_short      = short_q;
    assign o_owed       = owed_q;
    assign o_nickle_cnt = nickle_cnt_q;
    assign o_dime_cnt   = dime_cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: default instance plus one with an
// empty nickel inventory.
module tb_change_dispenser;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, soda = 1'b0, refill = 1'b0;
    logic [2:0] change = 3'd0;
    int         ack_mode = 0;
    int         sel = 0;

    logic       soda_a, soda_b, refill_a, refill_b, ack;
    logic       a_nick, a_dime, a_busy, a_done, a_short;
    logic       b_nick, b_dime, b_busy, b_done, b_short;
    logic [2:0] a_owed, b_owed;
    logic [4:0] a_ncnt, a_dcnt, b_ncnt, b_dcnt;

    logic       nick_m, dime_m, busy_m, done_m, short_m;
    logic [2:0] owed_m;
    logic [4:0] ncnt_m, dcnt_m;

    assign soda_a   = soda && (sel == 0);
    assign soda_b   = soda && (sel == 1);
    assign refill_a = refill && (sel == 0);
    assign refill_b = refill && (sel == 1);
    assign nick_m   = sel ? b_nick  : a_nick;
    assign dime_m   = sel ? b_dime  : a_dime;
    assign busy_m   = sel ? b_busy  : a_busy;
    assign done_m   = sel ? b_done  : a_done;
    assign short_m  = sel ? b_short : a_short;
    assign owed_m   = sel ? b_owed  : a_owed;
    assign ncnt_m   = sel ? b_ncnt  : a_ncnt;
    assign dcnt_m   = sel ? b_dcnt  : a_dcnt;
    // Mode 1: ack tied high; mode 2: ack only nickel requests.
    assign ack      = (ack_mode == 1) || (ack_mode == 2 && nick_m);

    change_dispenser u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_soda(soda_a), .i_change(change), .i_refill(refill_a),
        .i_coin_ack(ack), .o_nickle_out(a_nick), .o_dime_out(a_dime), .o_busy(a_busy),
        .o_done(a_done), .o_short(a_short), .o_owed(a_owed), .o_nickle_cnt(a_ncnt),
        .o_dime_cnt(a_dcnt)
    );

    change_dispenser #(.NICKLE_INIT(0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_soda(soda_b), .i_change(change), .i_refill(refill_b),
        .i_coin_ack(ack), .o_nickle_out(b_nick), .o_dime_out(b_dime), .o_busy(b_busy),
        .o_done(b_done), .o_short(b_short), .o_owed(b_owed), .o_nickle_cnt(b_ncnt),
        .o_dime_cnt(b_dcnt)
    );

    typedef struct {
        int lat; int dimes; int nickles; int dhigh; int owed; int shrt; int ncnt; int dcnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one vend; k counts edges after the accept edge E0.
    task automatic run_txn(input string tag, input logic [2:0] chg, input exp_t e);
        exp_t got, want;
        int   k;
        logic pd, pn;
        got = '{0, 0, 0, 0, 0, 0, 0, 0};
        @(negedge clk);
        soda = 1'b1;
        change = chg;
        sb.push_back(e);
        @(negedge clk);
        soda = 1'b0;
        k = 0; pd = 1'b0; pn = 1'b0;
        check_val({tag, "_busy_e0"}, busy_m, 1);
        while (1) begin
            if (dime_m) got.dhigh++;
            if (dime_m && !pd) got.dimes++;
            if (nick_m && !pn) got.nickles++;
            pd = dime_m;
            pn = nick_m;
            if (done_m || k >= 200) break;
            @(negedge clk);
            k++;
        end
        check_val({tag, "_done_seen"}, done_m, 1);
        got.lat = k; got.owed = owed_m; got.shrt = short_m;
        got.ncnt = ncnt_m; got.dcnt = dcnt_m;
        want = sb.pop_front();
        check_val({tag, "_latency"}, got.lat, want.lat);
        check_val({tag, "_dimes"}, got.dimes, want.dimes);
        check_val({tag, "_nickles"}, got.nickles, want.nickles);
        check_val({tag, "_dime_hi"}, got.dhigh, want.dhigh);
        check_val({tag, "_owed"}, got.owed, want.owed);
        check_val({tag, "_short"}, got.shrt, want.shrt);
        check_val({tag, "_ncnt"}, got.ncnt, want.ncnt);
        check_val({tag, "_dcnt"}, got.dcnt, want.dcnt);
        @(negedge clk);
        check_val({tag, "_done_drop"}, done_m, 0);
        check_val({tag, "_owed_idle"}, owed_m, 0);
        check_val({tag, "_busy_idle"}, busy_m, 0);
    endtask

    initial begin
        // Reset state
        sel = 0; ack_mode = 0;
        do_reset();
        repeat (3) @(negedge clk);
        check_val("rst_ncnt", a_ncnt, 8);
        check_val("rst_dcnt", a_dcnt, 8);
        check_val("rst_busy", a_busy, 0);
        check_val("rst_done", a_done, 0);
        check_val("rst_short", a_short, 0);
        check_val("rst_dime", a_dime, 0);
        check_val("rst_nick", a_nick, 0);
        check_val("rst_owed", a_owed, 0);
        check_val("rst_b_ncnt", b_ncnt, 0);

        // Two dimes
        ack_mode = 1;
        do_reset();
        run_txn("c4", 3'd4, '{5, 2, 0, 2, 0, 0, 8, 6});

        // Dime then nickel
        do_reset();
        run_txn("c3", 3'd3, '{5, 1, 1, 1, 0, 0, 7, 7});

        // Dime jam, fall back to four nickels
        ack_mode = 2;
        do_reset();
        run_txn("jam", 3'd4, '{25, 1, 4, 15, 0, 0, 4, 0});

        // No nickels: never overpay with a dime; then refill
        sel = 1; ack_mode = 1;
        do_reset();
        run_txn("nonick", 3'd1, '{1, 0, 0, 0, 1, 1, 0, 8});
        run_txn("b_c2", 3'd2, '{3, 1, 0, 1, 0, 0, 0, 7});
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        check_val("refill_ncnt", b_ncnt, 0);
        check_val("refill_dcnt", b_dcnt, 8);

        // Invalid code, then soda ignored while busy, then reset mid-wait
        sel = 0; ack_mode = 1;
        do_reset();
        run_txn("c7", 3'd7, '{0, 0, 0, 0, 7, 1, 8, 8});
        run_txn("c1", 3'd1, '{3, 0, 1, 0, 0, 0, 7, 8});
        ack_mode = 0;
        @(negedge clk);
        soda = 1'b1; change = 3'd2;
        @(negedge clk);
        soda = 1'b0;
        @(negedge clk);
        check_val("wait_dime", a_dime, 1);
        soda = 1'b1; change = 3'd4;
        @(negedge clk);
        soda = 1'b0;
        repeat (2) @(negedge clk);
        check_val("ign_dime", a_dime, 1);
        check_val("ign_nick", a_nick, 0);
        check_val("ign_done", a_done, 0);
        check_val("ign_busy", a_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_dime", a_dime, 0);
        check_val("midrst_done", a_done, 0);
        check_val("midrst_busy", a_busy, 0);
        check_val("midrst_ncnt", a_ncnt, 8);
        check_val("midrst_dcnt", a_dcnt, 8);
        @(negedge clk);
        check_val("midrst_done2", a_done, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Pays out the change owed after a vend, as a sequence of physical coins. It takes the vend strobe (i_soda) and the 3-bit change code (i_change, in 5-cent units, 0..4) from the vending controller. It drives a coin hopper with a request/ack handshake, one coin at a time, preferring dimes over nickels. It tracks on-hand nickel and dime inventory, handles hopper jams by timeout, and reports any unpaid remainder.

Parameters:
NICKLE_INIT, 8, nickel inventory loaded at reset and on refill
DIME_INIT, 8, dime inventory loaded at reset and on refill
CNT_W, 5, inventory counter width; must hold both INIT values
ACK_TIMEOUT, 15, consecutive WAIT_ACK cycles without i_coin_ack before the coin is declared jammed

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rst  in  1  reset, synchronous, active-high
i_soda  in  1  vend strobe; sampled only in IDLE
i_change  in  3  change owed in 5-cent units; valid codes 0..4; captured together with i_soda
i_refill  in  1  reload both inventories to their INIT values; honoured only in IDLE
i_coin_ack  in  1  hopper has ejected the requested coin
o_nickle_out  out  1  request one nickel; held until ack or timeout
o_dime_out  out  1  request one dime; held until ack or timeout
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when the transaction ends
o_short  out  1  one-cycle pulse with o_done when o_owed != 0
o_owed  out  3  unpaid units; valid only while o_done=1, otherwise 0
o_nickle_cnt  out  CNT_W  current nickel inventory
o_dime_cnt  out  CNT_W  current dime inventory

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, rem=0, timer=0, all 1-bit outputs 0, o_owed=0, o_nickle_cnt=NICKLE_INIT, o_dime_cnt=DIME_INIT.
- Reset mid-operation: any active request drops at the next edge, no o_done is produced, and inventory reloads.

FSM states: IDLE, SELECT, WAIT_ACK, FINISH.

- IDLE:
  - If i_refill=1, reload both counts to their INIT values.
  - If i_soda=1 and i_change<=4: set rem=i_change and go to SELECT.
  - If i_soda=1 and i_change is 5..7: set rem=i_change and go directly to FINISH, so the transaction reports short with o_owed = code.
  - If i_refill and i_soda arrive in the same cycle, both take effect; SELECT sees the refilled counts.
- SELECT (exactly one cycle); first matching rule wins:
  - rem==0 -> FINISH.
  - rem>=2 and dime_cnt>0 -> WAIT_ACK requesting a dime.
  - nickle_cnt>0 -> WAIT_ACK requesting a nickel.
  - Otherwise -> FINISH. Example: rem=1 with no nickels is never paid with a dime; the dispenser never overpays.
- WAIT_ACK:
  - The matching o_*_out is 1 from the edge that enters WAIT_ACK. Exactly one request is active at any time.
  - i_coin_ack=1 sampled: decrement the matching count, subtract 2 (dime) or 1 (nickel) from rem, drop the request, clear the timer, go to SELECT.
  - No ack: increment the timer. If the timer reaches ACK_TIMEOUT, the coin is jammed: force that coin's count to 0, drop the request, clear the timer, go to SELECT. SELECT then falls back to nickels or finishes short.
  - An ack in the final timeout cycle counts as a normal ack.
- FINISH (one cycle): o_done=1, o_owed=rem, o_short=(rem!=0); then go to IDLE.
- i_coin_ack outside WAIT_ACK is ignored.
- i_soda outside IDLE is ignored; upstream must honour o_busy. Any change offered while busy is lost by design.
- Counts never underflow: a coin is requested only when its count is >0.
- rem arithmetic is 3-bit; rem never goes below 0 because a dime is chosen only when rem>=2.
- Latency with ack tied to 1: the accept edge is E0; SELECT and WAIT_ACK alternate, 2 edges per coin; o_done is high after edge E(2n+1), where n is the number of coins dispensed.

Test Plan:
1. Reset, then hold idle for 3 cycles -> o_nickle_cnt=8, o_dime_cnt=8; o_busy, o_done, o_short, both requests and o_owed all 0.
2. Fresh reset, i_change=4 with i_soda pulse, i_coin_ack tied 1 -> two o_dime_out pulses, no nickel requests; o_done high after E5, o_owed=0, o_short=0; o_dime_cnt=6.
3. Fresh reset, i_change=3, ack tied 1 -> one dime then one nickel; o_done after E5; o_dime_cnt=7, o_nickle_cnt=7, o_owed=0.
4. Fresh reset, i_change=4, ack never asserted while o_dime_out=1 and asserted for nickels -> after 15 WAIT_ACK cycles o_dime_out drops and o_dime_cnt=0; then 4 nickels are dispensed, o_done with o_owed=0 and o_nickle_cnt=4.
5. NICKLE_INIT=0, i_change=1 -> no request issued; o_done and o_short high after E1, o_owed=1. Then i_refill in IDLE -> o_nickle_cnt=0, o_dime_cnt=8.
6. Combined case:
   - i_change=7 -> o_short after E0, o_owed=7.
   - A second i_soda during WAIT_ACK -> ignored.
   - i_rst during WAIT_ACK -> request 0 after the next edge, no o_done, counts back to INIT.
